// File: rtl/ncl_fullword_sink_sync.sv
// Clocked sink for an NCL full-word dual-rail result. It synchronizes every rail and
// detects DATA/NULL wavefronts. Each DATA word is handed off through a valid/ready slot.
module ncl_fullword_sink_sync #(
  parameter int unsigned W           = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [W-1:0]     sum_t,
  input  logic [W-1:0]     sum_f,
  input  logic             carry_t,
  input  logic             carry_f,
  output logic             comp_o,
  output logic [W-1:0]     out_data,
  output logic             out_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][W-1:0] st_q, sf_q;
  logic [SYNC_STAGES-1:0]        ct_q, cf_q;
  logic                          run_q;

  logic [W-1:0]     st, sf;
  logic             ct, cf;
  logic             all_data, all_null, any_ill;
  logic             comp_d, valid_d, carry_d, err_d;
  logic [W-1:0]     data_d;
  logic [CNT_W-1:0] cnt_d;

  // Per-rail synchronizer chains; reset to NULL.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      st_q <= '0;
      sf_q <= '0;
      ct_q <= '0;
      cf_q <= '0;
    end else begin
      st_q <= {st_q[SYNC_STAGES-2:0], sum_t};
      sf_q <= {sf_q[SYNC_STAGES-2:0], sum_f};
      ct_q <= {ct_q[SYNC_STAGES-2:0], carry_t};
      cf_q <= {cf_q[SYNC_STAGES-2:0], carry_f};
    end
  end

  // Reset release is retimed here, so the FSM first acts on the second edge after release.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  assign st = st_q[SYNC_STAGES-1];
  assign sf = sf_q[SYNC_STAGES-1];
  assign ct = ct_q[SYNC_STAGES-1];
  assign cf = cf_q[SYNC_STAGES-1];

  assign all_data = (&(st ^ sf)) & (ct ^ cf);
  assign all_null = ~(|(st | sf)) & ~(ct | cf);
  assign any_ill  = (|(st & sf)) | (ct & cf);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    comp_d  = comp_o;
    valid_d = out_valid;
    data_d  = out_data;
    carry_d = out_carry;
    err_d   = err_o;
    cnt_d   = word_cnt;
    if (run_q) begin
      if (any_ill) err_d = 1'b1;
      if (out_valid && out_ready) valid_d = 1'b0;
      case (state_q)
        WAIT_DATA: begin
          if (!any_ill && all_data && (!out_valid || out_ready)) begin
            data_d  = st;
            carry_d = ct;
            valid_d = 1'b1;
            comp_d  = 1'b1;
            cnt_d   = word_cnt + CNT_W'(1);
            state_d = WAIT_NULL;
          end
        end
        WAIT_NULL: begin
          if (!any_ill && all_null) begin
            comp_d  = 1'b0;
            state_d = WAIT_DATA;
          end
        end
        default: state_d = WAIT_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= WAIT_DATA;
      comp_o    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      err_o     <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      comp_o    <= comp_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_carry <= carry_d;
      err_o     <= err_d;
      word_cnt  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ncl_fullword_sink_sync.sv
// Bench for ncl_fullword_sink_sync: directed scenarios plus random words checked against
// an expected-word queue, a word counter and a sticky error flag.
module tb_ncl_fullword_sink_sync;

  localparam int unsigned W     = 32;
  localparam int unsigned SS    = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             init_n;
  logic [W-1:0]     sum_t, sum_f;
  logic             carry_t, carry_f;
  logic             comp_o;
  logic [W-1:0]     out_data;
  logic             out_carry;
  logic             out_valid;
  logic             out_ready;
  logic             err_o;
  logic [CNT_W-1:0] word_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic exp_err = 1'b0;
  logic [W:0] q[$];

  ncl_fullword_sink_sync #(.W(W), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
    .clk(clk), .init_n(init_n), .sum_t(sum_t), .sum_f(sum_f),
    .carry_t(carry_t), .carry_f(carry_f), .comp_o(comp_o),
    .out_data(out_data), .out_carry(out_carry), .out_valid(out_valid),
    .out_ready(out_ready), .err_o(err_o), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_data(input logic [W-1:0] d, input logic c);
    sum_t = d; sum_f = ~d; carry_t = c; carry_f = ~c;
  endtask

  task automatic drive_null();
    sum_t = '0; sum_f = '0; carry_t = 1'b0; carry_f = 1'b0;
  endtask

  // One cycle with optional random ready; any handshake must deliver the oldest expected word.
  task automatic rcycle(input bit force_ready);
    logic [W:0] e;
    out_ready = force_ready ? 1'b1 : 1'($urandom_range(0, 1));
    if (out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL handshake_unexpected got %h exp none", {out_carry, out_data});
      end else begin
        e = q.pop_front();
        if ({out_carry, out_data} !== e) begin
          errors++;
          $display("FAIL handshake_word got %h exp %h", {out_carry, out_data}, e);
        end
      end
    end
    tick(1);
  endtask

  task automatic test_reset();
    init_n = 1'b0; out_ready = 1'b1;
    sum_t = '1; sum_f = '0; carry_t = 1'b1; carry_f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if ({comp_o, out_valid, err_o, word_cnt} !== {3'b000, 4'd0}) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got %b exp 0000000", i, {comp_o, out_valid, err_o, word_cnt});
      end
    end
    drive_null();
    init_n = 1'b1;
    tick(4);
    checks++;
    if ({comp_o, out_valid, err_o, word_cnt} !== {3'b000, 4'd0}) begin
      errors++;
      $display("FAIL reset_release got %b exp 0000000", {comp_o, out_valid, err_o, word_cnt});
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_data(32'h0000_0001, 1'b0);
    exp_cnt++;
    tick(2);
    checks++;
    if (comp_o !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got comp %b valid %b exp 0 0", comp_o, out_valid);
    end
    tick(1);
    checks++;
    if ({out_data, out_carry, out_valid, comp_o, word_cnt} !== {32'h1, 1'b0, 1'b1, 1'b1, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL single_capture got %h %b %b %b %0d exp 00000001 0 1 1 %0d",
               out_data, out_carry, out_valid, comp_o, word_cnt, exp_cnt);
    end
    drive_null();
    tick(2);
    checks++;
    if (comp_o !== 1'b1) begin
      errors++;
      $display("FAIL single_null_early got %b exp 1", comp_o);
    end
    tick(1);
    checks++;
    if (comp_o !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_null got comp %b valid %b exp 0 0", comp_o, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a;
    a = $urandom;
    out_ready = 1'b0;
    drive_data(a, 1'b0);
    exp_cnt++;
    tick(3);
    checks++;
    if ({out_data, out_valid, comp_o, word_cnt} !== {a, 1'b1, 1'b1, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL bp_word_a got %h %b %b %0d exp %h 1 1 %0d", out_data, out_valid, comp_o, word_cnt, a, exp_cnt);
    end
    drive_null();
    tick(3);
    checks++;
    if (comp_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_null got %b exp 0", comp_o);
    end
    drive_data('1, 1'b1);
    tick(5);
    checks++;
    if ({out_data, out_valid, comp_o, word_cnt} !== {a, 1'b1, 1'b0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL bp_stall got %h %b %b %0d exp %h 1 0 %0d", out_data, out_valid, comp_o, word_cnt, a, exp_cnt);
    end
    out_ready = 1'b1;
    exp_cnt++;
    tick(1);
    checks++;
    if ({out_data, out_carry, out_valid, comp_o, word_cnt} !== {32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL bp_word_b got %h %b %b %b %0d exp ffffffff 1 1 1 %0d",
               out_data, out_carry, out_valid, comp_o, word_cnt, exp_cnt);
    end
    drive_null();
    tick(3);
    checks++;
    if (comp_o !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got comp %b valid %b exp 0 0", comp_o, out_valid);
    end
  endtask

  task automatic test_skew();
    logic [W-1:0] d;
    logic c;
    int order[W+1];
    int j, t;
    d = $urandom; c = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    for (int i = 0; i <= W; i++) order[i] = i;
    for (int i = W; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    drive_null();
    for (int i = 0; i <= W; i++) begin
      if (order[i] == W) begin
        carry_t = c; carry_f = ~c;
      end else begin
        sum_t[order[i]] = d[order[i]]; sum_f[order[i]] = ~d[order[i]];
      end
      tick(1);
      checks++;
      if (comp_o !== 1'b0 || out_valid !== 1'b0 || word_cnt !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL skew_partial step %0d got comp %b valid %b cnt %0d exp 0 0 %0d",
                 i, comp_o, out_valid, word_cnt, exp_cnt);
      end
    end
    exp_cnt++;
    tick(2);
    checks++;
    if ({out_data, out_carry, out_valid, comp_o, word_cnt} !== {d, c, 1'b1, 1'b1, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL skew_capture got %h %b %b %b %0d exp %h %b 1 1 %0d",
               out_data, out_carry, out_valid, comp_o, word_cnt, d, c, exp_cnt);
    end
    drive_null();
    tick(3);
    checks++;
    if (comp_o !== 1'b0) begin
      errors++;
      $display("FAIL skew_null got %b exp 0", comp_o);
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] d;
    d = $urandom;
    out_ready = 1'b1;
    sum_t = d | 32'h80; sum_f = ~d | 32'h80; carry_t = 1'b0; carry_f = 1'b1;
    exp_err = 1'b1;
    tick(4);
    checks++;
    if ({err_o, comp_o, out_valid, word_cnt} !== {1'b1, 1'b0, 1'b0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL illegal_freeze got err %b comp %b valid %b cnt %0d exp 1 0 0 %0d",
               err_o, comp_o, out_valid, word_cnt, exp_cnt);
    end
    drive_data(d, 1'b0);
    exp_cnt++;
    tick(3);
    checks++;
    if ({out_data, out_valid, comp_o, err_o, word_cnt} !== {d, 1'b1, 1'b1, 1'b1, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL illegal_recover got %h %b %b %b %0d exp %h 1 1 1 %0d",
               out_data, out_valid, comp_o, err_o, word_cnt, d, exp_cnt);
    end
    drive_null();
    tick(3);
    checks++;
    if (comp_o !== 1'b0 || err_o !== exp_err) begin
      errors++;
      $display("FAIL illegal_sticky got comp %b err %b exp 0 1", comp_o, err_o);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic c;
    int n;
    for (int k = 0; k < 20; k++) begin
      d = $urandom; c = 1'($urandom_range(0, 1));
      q.push_back({c, d});
      exp_cnt++;
      drive_data(d, c);
      n = 0;
      while (comp_o !== 1'b1 && n < 100) begin rcycle(0); n++; end
      checks++;
      if (comp_o !== 1'b1) begin
        errors++;
        $display("FAIL random_data_timeout word %0d got comp %b exp 1", k, comp_o);
      end
      drive_null();
      n = 0;
      while (comp_o !== 1'b0 && n < 100) begin rcycle(0); n++; end
      checks++;
      if (comp_o !== 1'b0) begin
        errors++;
        $display("FAIL random_null_timeout word %0d got comp %b exp 0", k, comp_o);
      end
    end
    for (int i = 0; i < 6; i++) rcycle(1);
    checks++;
    if (q.size() != 0 || word_cnt !== 4'(exp_cnt) || err_o !== exp_err) begin
      errors++;
      $display("FAIL random_final got left %0d cnt %0d err %b exp 0 %0d %b",
               q.size(), word_cnt, err_o, exp_cnt % 16, exp_err);
    end
  endtask

  task automatic test_wrap_reset();
    int rem;
    out_ready = 1'b1;
    rem = 16 - (exp_cnt % 16);
    for (int i = 0; i < rem; i++) begin
      drive_data($urandom, 1'($urandom_range(0, 1)));
      exp_cnt++;
      tick(3);
      drive_null();
      tick(3);
    end
    checks++;
    if (word_cnt !== 4'd0 || comp_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count got cnt %0d comp %b exp 0 0", word_cnt, comp_o);
    end
    drive_data(32'hA5A5_5A5A, 1'b1);
    tick(3);
    checks++;
    if (comp_o !== 1'b1 || word_cnt !== 4'd1) begin
      errors++;
      $display("FAIL wrap_pre_reset got comp %b cnt %0d exp 1 1", comp_o, word_cnt);
    end
    init_n = 1'b0;
    #1;
    exp_cnt = 0; exp_err = 1'b0;
    checks++;
    if ({comp_o, out_valid, out_data, out_carry, err_o, word_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_midhandshake got comp %b valid %b data %h carry %b err %b cnt %0d exp all 0",
               comp_o, out_valid, out_data, out_carry, err_o, word_cnt);
    end
    drive_null();
    tick(2);
    init_n = 1'b1;
    tick(3);
    drive_data(32'h1234_5678, 1'b0);
    exp_cnt++;
    tick(3);
    checks++;
    if ({out_data, out_valid, comp_o, word_cnt} !== {32'h1234_5678, 1'b1, 1'b1, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL post_reset_word got %h %b %b %0d exp 12345678 1 1 %0d",
               out_data, out_valid, comp_o, word_cnt, exp_cnt);
    end
    drive_null();
    tick(3);
  endtask

  initial begin
    init_n = 1'b0;
    out_ready = 1'b1;
    drive_null();
    test_reset();
    test_single();
    test_backpressure();
    test_skew();
    test_illegal();
    test_random();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
